bitmask_set_bit_sequencer: RTL and testbench
============================================

BITMASK_SET_BIT_SEQUENCER -- requirements
Module: bitmask_set_bit_sequencer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: width of the request word; legal values are 2 or greater.
REQ-002 SHALL have parameter INDEX_WIDTH, default 3: width of the grant index; it SHALL equal clog2(WORD_WIDTH).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port word_in, input, WORD_WIDTH bits: the request bitmask; each 1-bit is one pending job.
REQ-006 SHALL have port word_in_valid, input, 1 bit: word_in is valid.
REQ-007 SHALL have port word_in_ready, output, 1 bit: the block can accept a new word.
REQ-008 SHALL have port grant_onehot, output, WORD_WIDTH bits: the current grant, which is the rightmost 1-bit of the pending word.
REQ-009 SHALL have port grant_index, output, INDEX_WIDTH bits: the bit position of grant_onehot.
REQ-010 SHALL have port grant_last, output, 1 bit: the current grant is the final set bit of the word.
REQ-011 SHALL have port grant_valid, output, 1 bit: the grant outputs are valid.
REQ-012 SHALL have port grant_ready, input, 1 bit: the consumer accepts the grant.
REQ-013 SHALL have port abort, input, 1 bit: synchronous discard of all remaining pending bits.
REQ-014 SHALL have port zero_word, output, 1 bit: one-cycle pulse when an all-zero word is accepted.
REQ-015 SHALL have port grant_count, output, INDEX_WIDTH+1 bits: the number of grants completed for the current word.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and ISSUE, plus a WORD_WIDTH-bit pending register.
REQ-017 SHALL, in IDLE, hold word_in_ready=1 and grant_valid=0.
REQ-018 SHALL, in ISSUE, hold word_in_ready=0 and grant_valid=1.
REQ-019 SHALL, on an IDLE input handshake (word_in_valid and word_in_ready) with a nonzero word_in, load pending with word_in, clear grant_count to 0, and enter ISSUE on the next cycle.
REQ-020 SHALL, on an IDLE input handshake with word_in equal to 0, stay in IDLE, leave pending at 0, and assert zero_word for exactly the next cycle.
REQ-021 SHALL drive grant_onehot = pending AND NOT(pending - 1), computed modulo 2^WORD_WIDTH, i.e. the isolated rightmost 1-bit.
REQ-022 SHALL drive grant_index as the binary position of grant_onehot, combinationally from pending.
REQ-023 SHALL drive grant_last = 1 when (pending AND (pending - 1)) == 0.
REQ-024 SHALL, on a grant handshake (grant_valid and grant_ready), update pending to pending AND (pending - 1) and increment grant_count by 1.
REQ-025 SHALL, on a grant handshake with grant_last=1, return to IDLE.
REQ-026 SHALL hold all grant outputs stable while grant_valid=1 and grant_ready=0.
REQ-027 SHALL give a latency of exactly 1 cycle from input handshake to the first grant_valid.
REQ-028 SHALL, at full throughput, issue one grant per cycle, so a word with N set bits takes N cycles in ISSUE.
REQ-029 SHALL have no bubble between words: the input handshake may occur in the cycle immediately after the last grant handshake.
REQ-030 SHALL, on abort in ISSUE, clear pending and return to IDLE on the next cycle.
REQ-031 SHALL, when abort coincides with a grant handshake, count that grant as completed and increment grant_count.
REQ-032 SHALL ignore abort while in IDLE.
REQ-033 SHALL give abort no effect on a same-cycle input handshake.
REQ-034 SHALL hold grant_count in IDLE until the next nonzero word is accepted.
REQ-035 SHALL never let grant_count exceed WORD_WIDTH.

Reset
REQ-036 SHALL, while reset_n=0, immediately force: state IDLE, pending 0, grant_count 0, zero_word 0, grant_valid 0, and word_in_ready 0.
REQ-037 SHALL assert word_in_ready=1 on the first rising clock edge after reset_n deasserts.
REQ-038 SHALL, on reset mid-ISSUE, discard all pending bits and produce no further grants.

Verification
REQ-039 SHALL cover: word_in=8'b10101000 with grant_ready=1 -> three grants over three cycles: onehot 00001000/index 3, then 00100000/index 5, then 10000000/index 7 with grant_last=1; final grant_count=3.
REQ-040 SHALL cover: word_in=8'hFF with grant_ready toggling 1,0,1,0... -> 8 grants at indices 0 through 7 in order; outputs stable during stalls; grant_last only on index 7.
REQ-041 SHALL cover: word_in=8'h00 -> zero_word pulses for 1 cycle, no grant_valid, and word_in_ready stays 1.
REQ-042 SHALL cover: word_in=8'b01100110, with abort asserted together with the 2nd grant handshake -> grants at indices 1 and 2 only; grant_count=2; IDLE on the next cycle.
REQ-043 SHALL cover: reset_n pulled low asynchronously mid-ISSUE after 1 grant of 8'b11000011 -> grant_valid=0 immediately, and word_in_ready=1 one cycle after release.
REQ-044 SHALL cover: back-to-back words 8'h01 then 8'h80, with grant_ready=1 and word_in_valid held -> grants at index 0 then index 7, with a 1-cycle IDLE between them.

Source files
------------

// File: rtl/bitmask_set_bit_sequencer_if.sv
// Handshake bundle for bitmask_set_bit_sequencer.
//
// Carries the request-word side (word_in / word_in_valid / word_in_ready),
// the grant side (grant_onehot / grant_index / grant_last / grant_valid /
// grant_ready) and the side-band abort / zero_word / grant_count signals.
//   master : the producer/consumer environment (drives word_in, grant_ready, abort)
//   slave  : the sequencer itself
interface bitmask_set_bit_sequencer_if #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 3
);
  logic [WORD_WIDTH-1:0]  word_in;
  logic                   word_in_valid;
  logic                   word_in_ready;
  logic [WORD_WIDTH-1:0]  grant_onehot;
  logic [INDEX_WIDTH-1:0] grant_index;
  logic                   grant_last;
  logic                   grant_valid;
  logic                   grant_ready;
  logic                   abort;
  logic                   zero_word;
  logic [INDEX_WIDTH:0]   grant_count;

  modport master (
    output word_in, word_in_valid, grant_ready, abort,
    input  word_in_ready, grant_onehot, grant_index, grant_last,
           grant_valid, zero_word, grant_count
  );

  modport slave (
    input  word_in, word_in_valid, grant_ready, abort,
    output word_in_ready, grant_onehot, grant_index, grant_last,
           grant_valid, zero_word, grant_count
  );
endinterface

// File: rtl/bitmask_set_bit_sequencer.sv
// bitmask_set_bit_sequencer
//
// Accepts a request bitmask and issues one grant per set bit, lowest bit
// first. Each grant presents the isolated rightmost 1-bit of the pending
// word (one-hot and binary index) plus a flag marking the final bit.
// An all-zero word is consumed immediately and reported with a one-cycle
// zero_word pulse. abort drops whatever is still pending.
//
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave modport of bitmask_set_bit_sequencer_if
//     word_in/word_in_valid/word_in_ready : request word handshake
//     grant_onehot/grant_index/grant_last/grant_valid/grant_ready : grant handshake
//     abort       : discard remaining pending bits (only acts while issuing)
//     zero_word   : pulse the cycle after an all-zero word is accepted
//     grant_count : grants completed for the current word
//
// INDEX_WIDTH must equal clog2(WORD_WIDTH); WORD_WIDTH must be 2 or more.
module bitmask_set_bit_sequencer #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  bitmask_set_bit_sequencer_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  pending_q, pending_d;
  logic [INDEX_WIDTH:0]   count_q, count_d;
  logic                   zero_q, zero_d;
  // Low while in reset, high from the first clock edge afterwards; keeps
  // word_in_ready deasserted until the block has actually been clocked.
  logic                   live_q;

  logic [WORD_WIDTH-1:0]  pending_minus_one;
  logic [WORD_WIDTH-1:0]  pending_rest;
  logic [WORD_WIDTH-1:0]  onehot;
  logic [INDEX_WIDTH-1:0] index;
  logic                   last;
  logic                   in_ready;
  logic                   in_fire;
  logic                   grant_fire;

  // Rightmost-set-bit arithmetic: p & (p-1) clears the lowest 1-bit,
  // p & ~(p-1) isolates it. Both wrap modulo 2^WORD_WIDTH.
  assign pending_minus_one = pending_q - WORD_WIDTH'(1);
  assign pending_rest      = pending_q & pending_minus_one;
  assign onehot            = pending_q & ~pending_minus_one;
  assign last              = (pending_rest == '0);

  // onehot has at most one bit set, so OR-ing the positions of set bits
  // yields its binary index directly without a priority chain.
  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (onehot[i]) begin
        index = index | INDEX_WIDTH'(i);
      end
    end
  end

  assign in_ready   = live_q && (state_q == IDLE);
  assign in_fire    = in_ready && bus.word_in_valid;
  assign grant_fire = (state_q == ISSUE) && bus.grant_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (bus.word_in != '0) begin
            pending_d = bus.word_in;
            count_d   = '0;
            state_d   = ISSUE;
          end else begin
            zero_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (grant_fire) begin
          pending_d = pending_rest;
          count_d   = count_q + {{INDEX_WIDTH{1'b0}}, 1'b1};
          if (last) begin
            state_d = IDLE;
          end
        end
        // Abort overrides the pending update but a coinciding grant
        // still counts as completed.
        if (bus.abort) begin
          pending_d = '0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
      live_q    <= 1'b1;
    end
  end

  assign bus.word_in_ready = in_ready;
  assign bus.grant_valid   = (state_q == ISSUE);
  assign bus.grant_onehot  = onehot;
  assign bus.grant_index   = index;
  assign bus.grant_last    = last;
  assign bus.zero_word     = zero_q;
  assign bus.grant_count   = count_q;

endmodule

// File: tb/tb_bitmask_set_bit_sequencer.sv
// Self-checking bench for bitmask_set_bit_sequencer (WORD_WIDTH=8).
// Directed table of per-cycle vectors, hand-written multi-cycle sequences,
// then randomized traffic against a queue-based reference model.
module tb_bitmask_set_bit_sequencer;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bitmask_set_bit_sequencer_if #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) bus ();

  bitmask_set_bit_sequencer #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of pending bit positions, lowest first.
  bit m_busy;
  bit m_live;
  bit m_zero;
  int m_q[$];
  int m_cnt;

  typedef struct {
    logic [7:0] w;
    bit         v;
    bit         gr;
    bit         ab;
    bit         e_valid;
    bit         e_ready;
    logic [7:0] e_onehot;
    logic [2:0] e_index;
    bit         e_last;
    bit         e_zero;
    logic [3:0] e_count;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_live = 1'b0;
    m_zero = 1'b0;
    m_q.delete();
    m_cnt = 0;
  endfunction

  function automatic void model_step(input logic [7:0] w, input bit v, input bit gr, input bit ab);
    bit z;
    z = 1'b0;
    if (!m_busy) begin
      if (m_live && v) begin
        if (w != 8'h00) begin
          m_q.delete();
          for (int i = 0; i < 8; i++) if (w[i]) m_q.push_back(i);
          m_cnt  = 0;
          m_busy = 1'b1;
        end else begin
          z = 1'b1;
        end
      end
    end else begin
      if (gr) begin
        void'(m_q.pop_front());
        m_cnt++;
        if (m_q.size() == 0) m_busy = 1'b0;
      end
      if (ab) begin
        m_q.delete();
        m_busy = 1'b0;
      end
    end
    m_zero = z;
    m_live = 1'b1;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 32'(bus.word_in_ready), 32'(!m_busy && m_live));
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(m_busy));
    chk({tag, ".zero"},  32'(bus.zero_word), 32'(m_zero));
    chk({tag, ".count"}, 32'(bus.grant_count), 32'(m_cnt));
    if (m_busy) begin
      chk({tag, ".onehot"}, 32'(bus.grant_onehot), 32'(1) << m_q[0]);
      chk({tag, ".index"},  32'(bus.grant_index), 32'(m_q[0]));
      chk({tag, ".last"},   32'(bus.grant_last), 32'(m_q.size() == 1));
    end else begin
      chk({tag, ".onehot_idle"}, 32'(bus.grant_onehot), 32'(0));
    end
  endtask

  task automatic drive_edge(input logic [7:0] w, input bit v, input bit gr, input bit ab);
    bus.word_in       = w;
    bus.word_in_valid = v;
    bus.grant_ready   = gr;
    bus.abort         = ab;
    @(posedge clock);
    model_step(w, v, gr, ab);
    #1;
  endtask

  // Pulls reset low between edges, checks the immediate effect, then
  // releases it and checks word_in_ready one edge later.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, 32'(bus.grant_valid), 32'(0));
    chk({tag, ".rst_ready"}, 32'(bus.word_in_ready), 32'(0));
    chk({tag, ".rst_count"}, 32'(bus.grant_count), 32'(0));
    chk({tag, ".rst_zero"},  32'(bus.zero_word), 32'(0));
    model_reset();
    @(posedge clock);
    #1;
    chk({tag, ".rst_hold_ready"}, 32'(bus.word_in_ready), 32'(0));
    chk({tag, ".rst_hold_valid"}, 32'(bus.grant_valid), 32'(0));
    #2;
    reset_n = 1'b1;
    drive_edge(8'h00, 1'b0, 1'b0, 1'b0);
    chk({tag, ".post_rst_ready"}, 32'(bus.word_in_ready), 32'(1));
    check_model({tag, ".post_rst"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            w     v     gr    ab  | valid ready onehot index last  zero  count
    tbl[0]  = '{8'hA8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 3'd3, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0, 4'd1};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, 4'd2};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd3};
    tbl[4]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 4'd3};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd3};
    tbl[6]  = '{8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0, 4'd1};
    tbl[8]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd2};
    tbl[9]  = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 4'd0};
    tbl[10] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd1};
    tbl[11] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, 4'd0};
    tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd1};
    tbl[13] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0, 4'd0};
    tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0, 4'd0};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd0};

    bus.word_in       = 8'h00;
    bus.word_in_valid = 1'b0;
    bus.grant_ready   = 1'b0;
    bus.abort         = 1'b0;
    model_reset();

    // Reset state, then ready on the first edge after release.
    #3;
    chk("reset.ready", 32'(bus.word_in_ready), 32'(0));
    chk("reset.valid", 32'(bus.grant_valid), 32'(0));
    chk("reset.zero",  32'(bus.zero_word), 32'(0));
    chk("reset.count", 32'(bus.grant_count), 32'(0));
    #5;
    reset_n = 1'b1;
    drive_edge(8'h00, 1'b0, 1'b0, 1'b0);
    chk("release.ready", 32'(bus.word_in_ready), 32'(1));

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      drive_edge(tbl[i].w, tbl[i].v, tbl[i].gr, tbl[i].ab);
      chk($sformatf("tbl%0d.valid", i), 32'(bus.grant_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.ready", i), 32'(bus.word_in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d.zero", i),  32'(bus.zero_word), 32'(tbl[i].e_zero));
      chk($sformatf("tbl%0d.count", i), 32'(bus.grant_count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d.onehot", i), 32'(bus.grant_onehot), 32'(tbl[i].e_onehot));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d.index", i), 32'(bus.grant_index), 32'(tbl[i].e_index));
        chk($sformatf("tbl%0d.last", i),  32'(bus.grant_last), 32'(tbl[i].e_last));
      end
      check_model($sformatf("tbl%0d.model", i));
    end

    // 8'hFF with grant_ready toggling 1,0,1,0...: the grant shown before
    // edge k is bit (k+1)/2 and must hold across the stall cycles.
    drive_edge(8'hFF, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("ff%0d.valid", k),  32'(bus.grant_valid), 32'(1));
      chk($sformatf("ff%0d.index", k),  32'(bus.grant_index), 32'((k + 1) / 2));
      chk($sformatf("ff%0d.onehot", k), 32'(bus.grant_onehot), 32'(1) << ((k + 1) / 2));
      chk($sformatf("ff%0d.last", k),   32'(bus.grant_last), 32'(((k + 1) / 2) == 7));
      drive_edge(8'h00, 1'b0, (k % 2) == 0, 1'b0);
      check_model($sformatf("ff%0d.model", k));
    end
    chk("ff.final_count", 32'(bus.grant_count), 32'(8));
    chk("ff.final_idle",  32'(bus.word_in_ready), 32'(1));

    // Reset mid-issue after one grant of 8'hC3.
    drive_edge(8'hC3, 1'b1, 1'b0, 1'b0);
    drive_edge(8'h00, 1'b0, 1'b1, 1'b0);
    chk("c3.second_index", 32'(bus.grant_index), 32'(1));
    chk("c3.count1",       32'(bus.grant_count), 32'(1));
    bus.grant_ready = 1'b0;
    async_reset("c3");
    drive_edge(8'h00, 1'b0, 1'b1, 1'b0);
    chk("c3.no_more_grants", 32'(bus.grant_valid), 32'(0));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      if ($urandom_range(0, 7) == 0) w = 8'h00;
      drive_edge(w, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 15) == 0);
      check_model("rand");
      if ((n % 700) == 350) async_reset("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
